reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Board reset sequencer. Holds every channel in reset while the
//             clock manager is unlocked or the pushbutton is pressed. Releases
//             channels one at a time after a hold period. Once running, it
//             gives each channel its own software-reset pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int N_CH            = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 8,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            btn_n_i,
  input  logic            locked_i,
  input  logic [N_CH-1:0] sw_rst_i,
  output logic [N_CH-1:0] reset_o,
  output logic            ready_o,
  output logic [1:0]      state_o
);

  localparam int c_HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int c_SEQ_MAX = (N_CH - 1) * STAGE_GAP;
  localparam int c_SEQ_W   = (c_SEQ_MAX > 0) ? $clog2(c_SEQ_MAX + 1) : 1;
  localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_FULL = c_HOLD_W'(HOLD_CYCLES);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [c_SEQ_W-1:0]  c_SEQ_LAST  = c_SEQ_W'(c_SEQ_MAX);
  localparam logic [c_SEQ_W-1:0]  c_SEQ_ONE   = c_SEQ_W'(1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SEQ    = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [1:0]          r_lock_sync;
  logic [1:0]          r_btn_sync;
  logic                r_pressed;
  logic [c_DB_W-1:0]   r_db_cnt;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_HOLD_W-1:0] w_hold_nxt;
  logic [c_SEQ_W-1:0]  r_seq_cnt;
  logic [c_SEQ_W-1:0]  w_seq_nxt;
  logic [N_CH-1:0]     r_reset;
  logic [N_CH-1:0]     w_reset_nxt;
  logic [c_HOLD_W-1:0] r_sw_cnt [N_CH];
  logic [c_HOLD_W-1:0] w_sw_nxt [N_CH];
  logic                w_lock_s;
  logic                w_btn_s;
  logic                w_fault;

  assign w_lock_s = r_lock_sync[1];
  assign w_btn_s  = r_btn_sync[1];
  assign w_fault  = !w_lock_s || r_pressed;

  // Two-flop synchronisers; reset leaves lock absent and the button released.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_lock_sync <= 2'b00;
      r_btn_sync  <= 2'b11;
    end else begin
      r_lock_sync <= {r_lock_sync[0], locked_i};
      r_btn_sync  <= {r_btn_sync[0], btn_n_i};
    end
  end

  // Debounce: count consecutive samples that disagree with the current state.
  // A sample that agrees with the current state clears the count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pressed <= 1'b0;
      r_db_cnt  <= '0;
    end else if (w_btn_s == r_pressed) begin
      // btn_s is active low, so btn_s equal to pressed means the sample disagrees.
      if (r_db_cnt >= c_DB_LAST) begin
        r_pressed <= !r_pressed;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt  <= r_db_cnt + c_DB_ONE;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Sequencer state, counters and registered resets.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_ASSERT;
      r_hold_cnt <= '0;
      r_seq_cnt  <= '0;
      r_reset    <= '1;
      r_sw_cnt   <= '{default: '0};
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_seq_cnt  <= w_seq_nxt;
      r_reset    <= w_reset_nxt;
      r_sw_cnt   <= w_sw_nxt;
    end
  end

  // Next state and next resets. Software counters default to zero, so any
  // exit from RUN cancels their pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_seq_nxt   = r_seq_cnt;
    w_reset_nxt = r_reset;
    for (int k = 0; k < N_CH; k++) begin
      w_sw_nxt[k] = '0;
    end

    if (w_fault) begin
      w_state_nxt = ST_ASSERT;
      w_reset_nxt = '1;
      w_hold_nxt  = '0;
      w_seq_nxt   = '0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_state_nxt = ST_HOLD;
          w_reset_nxt = '1;
          w_hold_nxt  = '0;
        end
        ST_HOLD: begin
          w_reset_nxt = '1;
          if (r_hold_cnt >= c_HOLD_LAST) begin
            // Channel 0 releases at the first SEQ cycle itself.
            w_state_nxt    = ST_SEQ;
            w_seq_nxt      = '0;
            w_reset_nxt[0] = 1'b0;
          end else begin
            w_hold_nxt = r_hold_cnt + c_HOLD_ONE;
          end
        end
        ST_SEQ: begin
          if (!r_reset[N_CH-1]) begin
            w_state_nxt = ST_RUN;
          end else begin
            if (r_seq_cnt != c_SEQ_LAST) begin
              w_seq_nxt = r_seq_cnt + c_SEQ_ONE;
            end
            // Look one SEQ cycle ahead because the resets are registered.
            for (int k = 0; k < N_CH; k++) begin
              if (int'(r_seq_cnt) + 1 >= k * STAGE_GAP) begin
                w_reset_nxt[k] = 1'b0;
              end
            end
          end
        end
        ST_RUN: begin
          for (int k = 0; k < N_CH; k++) begin
            if (sw_rst_i[k]) begin
              w_sw_nxt[k]    = c_HOLD_FULL;
              w_reset_nxt[k] = 1'b1;
            end else if (r_sw_cnt[k] != '0) begin
              w_sw_nxt[k]    = r_sw_cnt[k] - c_HOLD_ONE;
              w_reset_nxt[k] = (r_sw_cnt[k] != c_HOLD_ONE);
            end else begin
              w_reset_nxt[k] = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_ASSERT;
          w_reset_nxt = '1;
        end
      endcase
    end
  end

  // In RUN a channel's reset is high only during its software pulse.
  assign ready_o = (r_state == ST_RUN) && (r_reset == '0);
  assign reset_o = r_reset;
  assign state_o = r_state;

endmodule
`default_nettype wire
